// File: rtl/input_network_pkg.sv
// Shared definitions for the challenge input network: default width, challenge type
// and a reference implementation of the bit mapping (package inet_pkg).
package inet_pkg;

    localparam int N_DEFAULT = 64;

    typedef logic [N_DEFAULT-1:0] chal_t;

    function automatic chal_t inet_map(chal_t x);
        chal_t y;
        y = '0;
        for (int j = 0; j < N_DEFAULT/2; j++) begin
            y[j] = x[2*j] ^ x[2*j+1];
        end
        y[N_DEFAULT/2] = x[0];
        for (int k = 1; k < N_DEFAULT/2; k++) begin
            y[N_DEFAULT/2+k] = x[2*k-1] ^ x[2*k];
        end
        return y;
    endfunction

endpackage

// File: rtl/input_network_if.sv
// Challenge in / transformed challenge out bundle between the challenge source and the APUF chains.
interface input_network_if #(
    parameter int N = inet_pkg::N_DEFAULT
);
    logic [N-1:0] x;
    logic         x_valid;
    logic [N-1:0] y;
    logic         y_valid;

    modport master (output x, output x_valid, input y, input y_valid);
    modport slave  (input x, input x_valid, output y, output y_valid);
endinterface

// File: rtl/input_network_map.sv
// Combinational challenge mapping x' -> y: adjacent-pair XORs in the low half,
// offset-by-one pair XORs (seeded with x'[0]) in the high half.
module input_network_map
    import inet_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [N-1:0] xp,
    output logic [N-1:0] y
);

    for (genvar j = 0; j < N/2; j++) begin : g_low
        assign y[j] = xp[2*j] ^ xp[2*j+1];
    end

    assign y[N/2] = xp[0];

    for (genvar k = 1; k < N/2; k++) begin : g_high
        assign y[N/2+k] = xp[2*k-1] ^ xp[2*k];
    end

endmodule

// File: rtl/input_network.sv
// Challenge input network top: optional left rotation (INNET_ROT_EN), mapping, one output register stage.
// Macro INNET_ROT_EN: when defined, x is rotated left by ROT before mapping; otherwise ROT is ignored.
module input_network
    import inet_pkg::*;
#(
    parameter int N   = N_DEFAULT,
    parameter int ROT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input_network_if.slave  bus
);

    if ((N % 2) != 0 || N < 4 || ROT < 0 || ROT >= N) begin : g_param_check
        $error("input_network: N must be even and >= 4, ROT must lie in 0..N-1");
    end

    logic [N-1:0] xp;
    logic [N-1:0] y_map;

`ifdef INNET_ROT_EN
    for (genvar i = 0; i < N; i++) begin : g_rot
        assign xp[i] = bus.x[(i + N - ROT) % N];
    end
`else
    assign xp = bus.x;
`endif

    input_network_map #(.N(N)) u_map (
        .xp (xp),
        .y  (y_map)
    );

    // y holds its last value between accepted challenges
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.y       <= '0;
            bus.y_valid <= 1'b0;
        end else begin
            bus.y_valid <= bus.x_valid;
            if (bus.x_valid) begin
                bus.y <= y_map;
            end
        end
    end

endmodule

// File: tb/tb_input_network.sv
// Scoreboard bench for input_network: randomized challenge stream against a word-level reference model.
module tb_input_network;
    import inet_pkg::*;

    localparam int N = 64;
`ifdef INNET_ROT_EN
    localparam int ROT = 1;
`else
    localparam int ROT = 0;
`endif

    typedef struct {
        logic         v;
        logic [N-1:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    input_network_if #(.N(N)) bus ();

    input_network #(.N(N), .ROT(ROT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t         q[$];
    int           vectors     = 0;
    int           miscompares = 0;
    logic [N-1:0] hold        = '0;
    bit           stim_done   = 1'b0;

    // Reference: low half = even bits of x^(x>>1), high half = even bits of x^(x<<1).
    function automatic logic [N-1:0] model(input logic [N-1:0] x);
        logic [N-1:0] xr, t, u, r;
        xr = (ROT == 0) ? x : ((x << ROT) | (x >> (N - ROT)));
        t  = xr ^ (xr >> 1);
        u  = xr ^ (xr << 1);
        r  = '0;
        for (int i = 0; i < N/2; i++) begin
            r[i]       = t[2*i];
            r[N/2 + i] = u[2*i];
        end
        return r;
    endfunction

    task automatic cycle(input logic r, input logic v, input logic [N-1:0] x,
                         input bit use_const, input logic [N-1:0] cexp);
        exp_t e;
        @(negedge clk);
        rst         = r;
        bus.x_valid = v;
        bus.x       = x;
        if (r) begin
            hold = '0;
            e.v  = 1'b0;
        end else if (v) begin
            hold = use_const ? cexp : model(x);
            e.v  = 1'b1;
        end else begin
            e.v  = 1'b0;
        end
        e.y = hold;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (bus.y_valid !== e.v || bus.y !== e.y) begin
                    miscompares++;
                    $display("FAIL out_check: got y_valid=%b y=%h, want y_valid=%b y=%h",
                             bus.y_valid, bus.y, e.v, e.y);
                end
            end
        end
    end

    initial begin : stimulus
        logic [N-1:0] rx;
        logic         rv;
        rst         = 1'b1;
        bus.x_valid = 1'b0;
        bus.x       = '0;

        cycle(1'b1, 1'b1, '1, 1'b0, '0);
        cycle(1'b1, 1'b1, '1, 1'b0, '0);

`ifdef INNET_ROT_EN
        cycle(1'b0, 1'b1, 64'h8000_0000_0000_0000, 1'b1, 64'h0000_0001_0000_0001);
        cycle(1'b0, 1'b0, '0, 1'b0, '0);
`else
        cycle(1'b0, 1'b1, 64'h0,                   1'b1, 64'h0);
        cycle(1'b0, 1'b1, '1,                      1'b1, 64'h0000_0001_0000_0000);
        cycle(1'b0, 1'b0, 64'h1234,                1'b0, '0);
        cycle(1'b0, 1'b1, 64'h1,                   1'b1, 64'h0000_0001_0000_0001);
        cycle(1'b0, 1'b1, 64'h2,                   1'b1, 64'h0000_0002_0000_0001);
        cycle(1'b0, 1'b0, '1,                      1'b0, '0);
        cycle(1'b0, 1'b1, 64'h8000_0000_0000_0000, 1'b1, 64'h0000_0000_8000_0000);
`endif

        for (int i = 0; i < 1000; i++) begin
            rx = {$urandom(), $urandom()};
            rv = ($urandom_range(0, 9) != 0);
            if (i == 300) begin
                rx = 64'hD0E7_20E9_A118_478C;
                rv = 1'b1;
            end
            if (i == 500) begin
                cycle(1'b1, 1'b1, rx, 1'b0, '0);
            end else begin
                cycle(1'b0, rv, rx, 1'b0, '0);
            end
        end

        cycle(1'b0, 1'b0, '0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0, 1'b0, '0);
        stim_done = 1'b1;
        @(posedge clk);
        #2;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: got stim_done=%0b, want 1", stim_done);
        $fatal(1, "bench timed out");
    end

endmodule
